// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared definitions for the parallel-in/serial-out
// transmitter.
//   state_e   : FSM state encoding (ST_IDLE / ST_SHIFT)
//   cnt_width : bit-counter width for a WIDTH-bit word. There is headroom
//               for an optional trailing parity bit, so the counter never
//               wraps inside a frame.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-bit loadable shift register.
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-high reset (clears the register)
//   load     in  : capture d (has priority over shift_en)
//   shift_en in  : advance the register by one bit toward the output end
//   d        in  : parallel word
//   ser_bit  out : bit currently at the output end
// LSB_FIRST=1 shifts right and presents bit 0. LSB_FIRST=0 shifts left and
// presents bit WIDTH-1.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic             ser_bit
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift_en)
            q <= LSB_FIRST ? {1'b0, q[WIDTH-1:1]} : {q[WIDTH-2:0], 1'b0};
    end

    assign ser_bit = LSB_FIRST ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter.
// It accepts a WIDTH-bit word through a valid/ready handshake and shifts the
// word out one bit per clk.
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-high reset
//   data_in    in  : parallel word (WIDTH bits)
//   load_valid in  : data_in is valid
//   load_ready out : a word can be accepted this cycle
//   ser_out    out : serial data bit (0 while idle)
//   ser_frame  out : ser_out carries a valid bit
//   done       out : pulse in the final bit cycle of a frame
// Build option PISO_PARITY_EN: an even-parity bit (XOR of the word) follows
// the data bits. In that case done and load_ready move to the parity cycle.
// If PISO_PARITY_EN is not defined, no parity logic exists.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_frame,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_bit, accept, shift_en, sr_bit;

    // Every output is decoded from state/counter. load_valid reaches only
    // the acceptance term.
    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST);
    assign load_ready = (state_q == ST_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;
    assign ser_frame  = (state_q == ST_SHIFT);
    assign done       = last_bit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    // A new word is accepted on the final bit, so the next
                    // frame follows with no gap.
                    cnt_d = '0;
                end else if (last_bit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    shift_en = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_en (shift_en),
        .d        (data_in),
        .ser_bit  (sr_bit)
    );

`ifdef PISO_PARITY_EN
    logic par_q;

    // Parity is captured together with the word, so later changes on
    // data_in cannot affect the frame that is already being sent.
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^data_in;
    end

    assign ser_out = (state_q == ST_SHIFT) &&
                     ((cnt_q == CW'(WIDTH)) ? par_q : sr_bit);
`else
    assign ser_out = (state_q == ST_SHIFT) && sr_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 9 : 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       load_valid;
    logic       rdy_l, so_l, fr_l, dn_l;
    logic       rdy_m, so_m, fr_m, dn_m;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy_l), .ser_out(so_l), .ser_frame(fr_l), .done(dn_l)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(rdy_m), .ser_out(so_m), .ser_frame(fr_m), .done(dn_m)
    );

    // Expected serial cycle: the bit itself and whether it is the frame's last.
    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    // Stimulus vector: word plus hand-derived bit sequences in transmit order
    // (first bit in position 7) for each bit order, and even parity.
    typedef struct {
        logic [7:0] data;
        logic [7:0] seq_l;
        logic [7:0] seq_m;
        logic       par;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] sl, input logic [7:0] sm, input logic p);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.last = (i == 7) && !PAR;
            e.b = sl[7-i]; qa.push_back(e);
            e.b = sm[7-i]; qb.push_back(e);
        end
        if (PAR) begin
            e.b = p; e.last = 1'b1;
            qa.push_back(e);
            qb.push_back(e);
        end
    endtask

    // Single word: accept, scramble data_in, wait until idle again.
    task automatic send(input vec_t v);
        data_in    = v.data;
        load_valid = 1'b1;
        @(posedge clk); #1;
        push(v.seq_l, v.seq_m, v.par);
        load_valid = 1'b0;
        data_in    = ~v.data;
        repeat (NB + 1) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every cycle either pops an expected frame bit or expects idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                chk("l_frame", fr_l, 1);
                chk("l_bit", so_l, ea.b);
                chk("l_done", dn_l, ea.last);
                chk("l_ready", rdy_l, ea.last);
            end else begin
                chk("l_idle_frame", fr_l, 0);
                chk("l_idle_out", so_l, 0);
                chk("l_idle_done", dn_l, 0);
                chk("l_idle_ready", rdy_l, 1);
            end
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                chk("m_frame", fr_m, 1);
                chk("m_bit", so_m, eb.b);
                chk("m_done", dn_m, eb.last);
                chk("m_ready", rdy_m, eb.last);
            end else begin
                chk("m_idle_frame", fr_m, 0);
                chk("m_idle_out", so_m, 0);
                chk("m_idle_done", dn_m, 0);
                chk("m_idle_ready", rdy_m, 1);
            end
        end
    end

    initial begin
        tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
        tbl[1] = '{8'h81, 8'b10000001, 8'b10000001, 1'b0};
        tbl[2] = '{8'h07, 8'b11100000, 8'b00000111, 1'b1};
        tbl[3] = '{8'h6B, 8'b11010110, 8'b01101011, 1'b1};
        tbl[4] = '{8'hF0, 8'b00001111, 8'b11110000, 1'b0};
        tbl[5] = '{8'h01, 8'b10000000, 8'b00000001, 1'b1};

        // Reset held 3 cycles with load_valid high: no frame may start.
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven single words.
        for (int i = 0; i < 6; i++) send(tbl[i]);

        // Back-to-back: valid held, FF then 00 with no gap.
        data_in    = 8'hFF;
        load_valid = 1'b1;
        @(posedge clk); #1;
        push(8'hFF, 8'hFF, 1'b0);
        data_in = 8'h00;
        repeat (NB) @(posedge clk);
        #1;
        push(8'h00, 8'h00, 1'b0);
        load_valid = 1'b0;
        repeat (NB + 1) @(posedge clk);
        #1;

        // load_valid pulsed while load_ready=0 must be ignored.
        data_in    = 8'h6B;
        load_valid = 1'b1;
        @(posedge clk); #1;
        push(8'b11010110, 8'b01101011, 1'b1);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        data_in    = 8'h55;
        load_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (NB - 3) @(posedge clk);
        #1;

        // Mid-frame reset in bit cycle 4: frame abandoned, next word whole.
        data_in    = 8'h3C;
        load_valid = 1'b1;
        @(posedge clk); #1;
        push(8'b00111100, 8'b00111100, 1'b0);
        load_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        qa.delete();
        qb.delete();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(tbl[5]);
        send(tbl[3]);

        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("drain_l", qa.size(), 0);
        chk("drain_m", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
